int_ctrl_nested: RTL and testbench

Parametrised, vectored, priority-based interrupt controller with nested preemption and a hardware return-address stack. It sits beside the CPU fetch stage. It collects software-set and edge-detected hardware interrupt requests, and gates them through per-source enables and a global enable. It redirects the PC to a per-source vector, or back to the saved return address on end-of-routine.

---
 rtl/int_ctrl_pkg.sv | 34 +++
 rtl/int_ret_stack.sv | 48 ++++
 rtl/int_ctrl_nested.sv | 127 ++++++++++++
 tb/tb_int_ctrl_nested.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants, event type and priority encoder
// for the nested vectored interrupt controller.
package int_ctrl_pkg;

   localparam int DEF_VEC_BASE   = 'h0100;
   localparam int DEF_VEC_STRIDE = 4;
   localparam int MAX_INT        = 32;
   localparam int MAX_IDX_W      = 5;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_ENTER,
      EV_RETURN
   } ev_t;

   typedef struct packed {
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
   } prio_t;

   // Lowest set bit wins; scanning downward lets it overwrite.
   function automatic prio_t prio_enc(input logic [MAX_INT-1:0] vec);
      prio_t r;
      r = '0;
      for (int i = MAX_INT - 1; i >= 0; i--) begin
         if (vec[i]) begin
            r.found = 1'b1;
            r.idx   = MAX_IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/int_ret_stack.sv
// int_ret_stack: small LIFO holding {return pc, level} entries
// for nested interrupt service.
module int_ret_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   assign wr_ptr = PW'(cnt);
   assign rd_ptr = PW'(cnt - 1'b1);
   assign full   = (cnt == CW'(DEPTH));
   assign empty  = (cnt == '0);
   assign top    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (push && !full) begin
         cnt <= cnt + 1'b1;
      end else if (pop && !empty) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Storage needs no reset: only entries below cnt are ever read.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/int_ctrl_nested.sv
// int_ctrl_nested: vectored priority interrupt controller with
// nested preemption and a hardware return-address stack.
module int_ctrl_nested
   import int_ctrl_pkg::*;
#(
   parameter int NUM_INT    = 16,
   parameter int ADDR_W     = 16,
   parameter int NEST_DEPTH = 4,
   parameter int VEC_BASE   = DEF_VEC_BASE,
   parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(NUM_INT):0]   reg_addr,
   input  logic                       ier_set,
   input  logic                       ier_clr,
   input  logic                       ifr_set,
   input  logic                       ifr_clr,
   input  logic [NUM_INT-1:0]         irq_in,
   input  logic [ADDR_W-1:0]          pc_in,
   input  logic                       reti,
   output logic                       take,
   output logic [ADDR_W-1:0]          addr_out,
   output logic                       in_service,
   output logic [$clog2(NUM_INT)-1:0] active_id,
   output logic                       reti_err
);

   localparam int IDW = $clog2(NUM_INT);
   localparam int LW  = IDW + 1;
   localparam int SW  = ADDR_W + LW;

   logic [NUM_INT:0]   ier;
   logic [NUM_INT:0]   ier_hot;
   logic [NUM_INT:0]   ier_s;
   logic [NUM_INT:0]   ier_c;
   logic [NUM_INT-1:0] ifr;
   logic [NUM_INT-1:0] irq_q;
   logic [NUM_INT-1:0] pend;
   logic [NUM_INT-1:0] ifr_hot;
   logic [NUM_INT-1:0] ack_hot;
   logic [NUM_INT-1:0] set_v;
   logic [NUM_INT-1:0] clr_v;
   logic [LW-1:0]      cur_lvl;
   logic [LW-1:0]      win_lvl;
   logic [ADDR_W-1:0]  vec_addr;
   logic [SW-1:0]      top;
   logic               full;
   logic               empty;
   logic               ret_ok;
   logic               enter_ok;
   prio_t              win;
   ev_t                ev;

   assign pend     = ier[NUM_INT-1:0] & ifr;
   assign win      = prio_enc(MAX_INT'(pend));
   assign win_lvl  = LW'(win.idx);
   assign vec_addr = ADDR_W'(VEC_BASE + VEC_STRIDE * int'(win_lvl));

   assign ret_ok   = reti && !empty;
   assign enter_ok = ier[NUM_INT] && win.found &&
                     (win_lvl < cur_lvl) && !full && !reti;

   always_comb begin
      ev = EV_NONE;
      unique case (1'b1)
         ret_ok:   ev = EV_RETURN;
         enter_ok: ev = EV_ENTER;
         default:  ev = EV_NONE;
      endcase
   end

   // Out-of-range register indices shift the one-hot to zero.
   assign ifr_hot = NUM_INT'(1) << reg_addr;
   assign ier_hot = (NUM_INT+1)'(1) << reg_addr;
   assign ier_s   = ier_set ? ier_hot : '0;
   assign ier_c   = ier_clr ? ier_hot : '0;
   assign ack_hot = (ev == EV_ENTER) ? (NUM_INT'(1) << win_lvl) : '0;
   assign set_v   = (irq_in & ~irq_q) | (ifr_set ? ifr_hot : '0);
   assign clr_v   = (ifr_clr ? ifr_hot : '0) | ack_hot;

   int_ret_stack #(
      .WIDTH (SW),
      .DEPTH (NEST_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (ev == EV_ENTER),
      .pop   (ev == EV_RETURN),
      .din   ({pc_in, cur_lvl}),
      .top   (top),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ier      <= '0;
         ifr      <= '0;
         irq_q    <= '0;
         cur_lvl  <= LW'(NUM_INT);
         take     <= 1'b0;
         addr_out <= '0;
         reti_err <= 1'b0;
      end else begin
         ier      <= (ier & ~ier_c) | ier_s;
         ifr      <= (ifr & ~clr_v) | set_v;
         irq_q    <= irq_in;
         take     <= (ev != EV_NONE);
         reti_err <= reti && empty;
         unique case (ev)
            EV_ENTER: begin
               cur_lvl  <= win_lvl;
               addr_out <= vec_addr;
            end
            EV_RETURN: begin
               {addr_out, cur_lvl} <= top;
            end
            default: ;
         endcase
      end
   end

   assign in_service = !empty;
   assign active_id  = in_service ? cur_lvl[IDW-1:0] : '0;

endmodule

// File: tb/tb_int_ctrl_nested.sv
// tb_int_ctrl_nested: directed and random checks of int_ctrl_nested
// against a queue-based behavioural model.
module tb_int_ctrl_nested;

   localparam int N  = 16;
   localparam int AW = 16;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    reg_addr = '0;
   logic          ier_set = 1'b0;
   logic          ier_clr = 1'b0;
   logic          ifr_set = 1'b0;
   logic          ifr_clr = 1'b0;
   logic [N-1:0]  irq_in = '0;
   logic [AW-1:0] pc_in = '0;
   logic          reti = 1'b0;
   logic          take;
   logic [AW-1:0] addr_out;
   logic          in_service;
   logic [3:0]    active_id;
   logic          reti_err;

   int checks = 0;
   int errors = 0;

   bit [N:0]   m_ier;
   bit [N-1:0] m_ifr;
   bit [N-1:0] m_irq_q;
   int         m_lvl;
   int         m_pc[$];
   int         m_sl[$];
   bit         m_take;
   bit         m_err;
   int         m_addr;

   always #5 clk = ~clk;

   int_ctrl_nested #(
      .NUM_INT    (N),
      .ADDR_W     (AW),
      .NEST_DEPTH (D),
      .VEC_BASE   ('h0100),
      .VEC_STRIDE (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .reg_addr   (reg_addr),
      .ier_set    (ier_set),
      .ier_clr    (ier_clr),
      .ifr_set    (ifr_set),
      .ifr_clr    (ifr_clr),
      .irq_in     (irq_in),
      .pc_in      (pc_in),
      .reti       (reti),
      .take       (take),
      .addr_out   (addr_out),
      .in_service (in_service),
      .active_id  (active_id),
      .reti_err   (reti_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ier = '0;
      m_ifr = '0;
      m_irq_q = '0;
      m_lvl = N;
      m_pc.delete();
      m_sl.delete();
      m_take = 0;
      m_err = 0;
      m_addr = 0;
   endtask

   task automatic model_step();
      int p;
      bit [N-1:0] setv;
      bit [N-1:0] clrv;
      p = -1;
      for (int i = N - 1; i >= 0; i--)
         if (m_ier[i] && m_ifr[i]) p = i;
      setv = irq_in & ~m_irq_q;
      clrv = '0;
      if (ifr_set && reg_addr < N) setv[reg_addr[3:0]] = 1'b1;
      if (ifr_clr && reg_addr < N) clrv[reg_addr[3:0]] = 1'b1;
      m_take = 0;
      m_err = 0;
      if (reti) begin
         if (m_pc.size() > 0) begin
            m_addr = m_pc.pop_back();
            m_lvl = m_sl.pop_back();
            m_take = 1;
         end else begin
            m_err = 1;
         end
      end else if (m_ier[N] && p >= 0 && p < m_lvl && m_pc.size() < D) begin
         m_pc.push_back(int'(pc_in));
         m_sl.push_back(m_lvl);
         m_lvl = p;
         clrv[p] = 1'b1;
         m_take = 1;
         m_addr = ('h0100 + 4 * p) & 'hFFFF;
      end
      m_ifr = (m_ifr & ~clrv) | setv;
      if (reg_addr <= N) begin
         if (ier_set) m_ier[reg_addr] = 1'b1;
         else if (ier_clr) m_ier[reg_addr] = 1'b0;
      end
      m_irq_q = irq_in;
   endtask

   task automatic check_outputs();
      bit busy;
      busy = (m_pc.size() > 0);
      chk("take", 32'(take), 32'(m_take));
      chk("addr_out", 32'(addr_out), 32'(m_addr));
      chk("in_service", 32'(in_service), 32'(busy));
      chk("active_id", 32'(active_id), busy ? 32'(m_lvl) : 32'd0);
      chk("reti_err", 32'(reti_err), 32'(m_err));
      chk("ifr", 32'(dut.ifr), 32'(m_ifr));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
      ier_set = 0;
      ier_clr = 0;
      ifr_set = 0;
      ifr_clr = 0;
      reti = 0;
   endtask

   task automatic pulse(input int a, input int kind);
      reg_addr = 5'(a);
      ier_set = (kind == 0);
      ier_clr = (kind == 1);
      ifr_set = (kind == 2);
      ifr_clr = (kind == 3);
      step();
   endtask

   task automatic unwind();
      for (int i = 0; i < 4 * D && m_pc.size() > 0; i++) begin
         reti = 1;
         step();
         step();
      end
      chk("unwind_idle", 32'(in_service), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_take"}, 32'(take), 32'd0);
      chk({tag, "_addr"}, 32'(addr_out), 32'd0);
      chk({tag, "_insvc"}, 32'(in_service), 32'd0);
      chk({tag, "_id"}, 32'(active_id), 32'd0);
      chk({tag, "_err"}, 32'(reti_err), 32'd0);
   endtask

   localparam int IER_SET = 0;
   localparam int IER_CLR = 1;
   localparam int IFR_SET = 2;
   localparam int IFR_CLR = 3;

   initial begin
      model_reset();
      #2 rst = 0;
      #1 check_reset("rst0");
      @(negedge clk) rst = 1;

      // simple entry
      pulse(3, IER_SET);
      pulse(N, IER_SET);
      pc_in = 16'h0040;
      pulse(3, IFR_SET);
      chk("t1_lat", 32'(take), 32'd0);
      step();
      chk("t1_take", 32'(take), 32'd1);
      chk("t1_addr", 32'(addr_out), 32'h010C);
      chk("t1_ifr3", 32'(dut.ifr[3]), 32'd0);
      chk("t1_id", 32'(active_id), 32'd3);

      // nesting
      pulse(1, IER_SET);
      pc_in = 16'h0080;
      irq_in[1] = 1;
      step();
      step();
      chk("t2_addr", 32'(addr_out), 32'h0104);
      irq_in[1] = 0;
      step();
      chk("t2_once", 32'(take), 32'd0);
      reti = 1;
      step();
      chk("t2_ret1", 32'(addr_out), 32'h0080);
      chk("t2_id", 32'(active_id), 32'd3);
      reti = 1;
      step();
      chk("t2_ret2", 32'(addr_out), 32'h0040);
      chk("t2_idle", 32'(in_service), 32'd0);

      // lower priority waits
      pulse(5, IER_SET);
      pc_in = 16'h0200;
      pulse(1, IFR_SET);
      step();
      pulse(5, IFR_SET);
      step();
      chk("t3_nopre", 32'(take), 32'd0);
      reti = 1;
      step();
      chk("t3_ret", 32'(addr_out), 32'h0200);
      step();
      chk("t3_tail", 32'(take), 32'd1);
      chk("t3_taddr", 32'(addr_out), 32'h0114);
      unwind();

      // stack full
      pulse(6, IER_SET);
      pulse(4, IER_SET);
      pulse(2, IER_SET);
      pulse(0, IER_SET);
      foreach (m_ier[i]) if (i == 99) chk("never", 0, 0);
      for (int k = 0; k < 4; k++) begin
         int src;
         src = (k == 0) ? 6 : (k == 1) ? 4 : (k == 2) ? 3 : 2;
         pc_in = 16'(16'h1000 + src);
         pulse(src, IFR_SET);
         step();
      end
      chk("t4_id", 32'(active_id), 32'd2);
      pulse(0, IFR_SET);
      step();
      step();
      chk("t4_block", 32'(take), 32'd0);
      chk("t4_ifr0", 32'(dut.ifr[0]), 32'd1);
      reti = 1;
      step();
      chk("t4_ret", 32'(addr_out), 32'h1002);
      step();
      chk("t4_tail", 32'(addr_out), 32'h0100);
      unwind();

      // set beats clear
      reg_addr = 7;
      ifr_clr = 1;
      irq_in[7] = 1;
      step();
      chk("c1_ifr7", 32'(dut.ifr[7]), 32'd1);
      irq_in[7] = 0;
      pulse(7, IFR_CLR);
      pulse(0, IFR_SET);
      irq_in[0] = 1;
      step();
      chk("c2_take", 32'(take), 32'd1);
      chk("c2_ifr0", 32'(dut.ifr[0]), 32'd1);
      irq_in[0] = 0;
      unwind();

      // reti while idle
      reti = 1;
      step();
      chk("e1_err", 32'(reti_err), 32'd1);
      chk("e1_take", 32'(take), 32'd0);
      step();
      chk("e1_pulse", 32'(reti_err), 32'd0);

      // reset mid-handler
      pc_in = 16'h0300;
      pulse(6, IFR_SET);
      step();
      pulse(4, IFR_SET);
      step();
      chk("r1_id", 32'(active_id), 32'd4);
      rst = 0;
      #1 check_reset("r1");
      model_reset();
      @(negedge clk) rst = 1;
      repeat (3) step();
      chk("r1_notake", 32'(take), 32'd0);

      // random traffic
      pulse(N, IER_SET);
      for (int n = 0; n < 1500; n++) begin
         int r;
         r = $urandom_range(0, 15);
         reg_addr = ($urandom_range(0, 7) == 0) ?
                    5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
         ier_set = (r < 3);
         ier_clr = (r == 3) || (r == 15 && $urandom_range(0, 1) == 0);
         ifr_set = (r == 4) || (r == 5);
         ifr_clr = (r == 6) || (r == 15);
         if (r == 7) reg_addr = 5'(N);
         reti = ($urandom_range(0, 5) == 0);
         irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
         pc_in = AW'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
